// File: rtl/bus_burst_master_pkg.sv
// Shared definitions for the burst bus master.
//   busState_e  : master FSM states
//   BURST_W     : width of the command burst field (words-1)
//   BUS_BURST_W : width of the bus burstSize field
//   burstWords(): converts a words-1 burst field into a word count
package bus_burst_master_pkg;

  localparam int BURST_W     = 4;
  localparam int BUS_BURST_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_BEGIN = 3'd2,
    S_WDATA = 3'd3,
    S_WEND  = 3'd4,
    S_RDATA = 3'd5
  } busState_e;

  function automatic logic [4:0] burstWords(input logic [BURST_W-1:0] burst);
    return {1'b0, burst} + 5'd1;
  endfunction

endpackage

// File: rtl/bus_wdata_fifo.sv
// Write-data buffer for the burst master: FIFO_DEPTH x 32 words.
//   clk, rst          : clock, synchronous active-high clear (empties buffer)
//   push, pushData    : write a word; ignored while full
//   pop               : remove the head word
//   drop, dropCount   : remove dropCount words at once (aborted burst); wins over pop
//   headData          : word at the head of the buffer
//   full, count       : status
module bus_wdata_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [31:0]                   pushData,
  input  logic                          pop,
  input  logic                          drop,
  input  logic [$clog2(FIFO_DEPTH):0]   dropCount,
  output logic [31:0]                   headData,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             pushOk;
  logic [CNT_W-1:0] popAmount;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign pushOk    = push && !full;
  assign popAmount = drop ? dropCount : CNT_W'(pop);
  assign headData  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (pushOk && !rst) mem[wrPtr] <= pushData;
  end

  // Pointers are PTR_W bits wide, so adding a count wraps modulo FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PTR_W'(pushOk);
      rdPtr <= rdPtr + PTR_W'(popAmount);
      count <= count + CNT_W'(pushOk) - popAmount;
    end
  end

endmodule

// File: rtl/bus_burst_master.sv
// Burst bus master: accepts read/write burst commands, arbitrates for the bus
// and runs one burst at a time on a wired-OR bus.
//   cmd_*          : command port (valid/ready)
//   wr_*           : write-data buffer fill port
//   rd_valid/data  : read data stream (1-cycle latency, no backpressure)
//   done/error     : single-cycle completion / abort pulses
//   bus_request/grant, bus_*_o, bus_*_i : arbiter and bus side
//   dbgState_o     : current FSM state for observation
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid_i && cmd_ready_o. cmd_ready_o is high only in IDLE and, for a
// write, only once the buffer already holds the whole burst, so a write burst
// can never underrun. cmd_ready_o does not depend on cmd_valid_i.
module bus_burst_master
  import bus_burst_master_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_read_i,
  input  logic [31:0]            cmd_addr_i,
  input  logic [BURST_W-1:0]     cmd_burst_i,
  input  logic [3:0]             cmd_be_i,
  input  logic                   wr_push_i,
  input  logic [31:0]            wr_data_i,
  output logic                   wr_full_o,
  output logic [4:0]             wr_count_o,
  output logic                   rd_valid_o,
  output logic [31:0]            rd_data_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   bus_request_o,
  input  logic                   bus_grant_i,
  output logic                   bus_beginTransaction_o,
  output logic                   bus_endTransaction_o,
  output logic [31:0]            bus_addrData_o,
  output logic [3:0]             bus_byteEnables_o,
  output logic [BUS_BURST_W-1:0] bus_burstSize_o,
  output logic                   bus_readNWrite_o,
  output logic                   bus_dataValid_o,
  input  logic [31:0]            bus_addrData_i,
  input  logic                   bus_dataValid_i,
  input  logic                   bus_endTransaction_i,
  input  logic                   bus_busy_i,
  input  logic                   bus_error_i,
  output busState_e              dbgState_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  busState_e          state, stateNext;
  logic [31:0]        addrQ;
  logic [BURST_W-1:0] burstQ;
  logic [3:0]         beQ;
  logic               readQ;
  logic [4:0]         wordsLeftQ, wordsLeftNext;
  logic [4:0]         rdCountQ, rdCountNext;
  logic               rdValidQ;
  logic [31:0]        rdDataQ;

  logic               cmdAccept;
  logic               fifoPop, fifoDrop, fifoFull;
  logic [31:0]        fifoHead;
  logic [CNT_W-1:0]   fifoCount;

  bus_wdata_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) wdataFifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (wr_push_i),
    .pushData  (wr_data_i),
    .pop       (fifoPop),
    .drop      (fifoDrop),
    .dropCount (CNT_W'(wordsLeftQ)),
    .headData  (fifoHead),
    .full      (fifoFull),
    .count     (fifoCount)
  );

  // Every output is forced low while rst_i is high, even mid-transaction.
  always_comb begin
    stateNext              = state;
    wordsLeftNext          = wordsLeftQ;
    rdCountNext            = rdCountQ;
    cmd_ready_o            = 1'b0;
    cmdAccept              = 1'b0;
    fifoPop                = 1'b0;
    fifoDrop               = 1'b0;
    done_o                 = 1'b0;
    error_o                = 1'b0;
    bus_request_o          = 1'b0;
    bus_beginTransaction_o = 1'b0;
    bus_endTransaction_o   = 1'b0;
    bus_addrData_o         = '0;
    bus_byteEnables_o      = '0;
    bus_burstSize_o        = '0;
    bus_readNWrite_o       = 1'b0;
    bus_dataValid_o        = 1'b0;
    if (!rst_i) begin
      case (state)
        S_IDLE: begin
          cmd_ready_o = cmd_read_i || (fifoCount >= CNT_W'(burstWords(cmd_burst_i)));
          cmdAccept   = cmd_valid_i && cmd_ready_o;
          if (cmdAccept) stateNext = S_REQ;
        end
        S_REQ: begin
          bus_request_o = 1'b1;
          if (bus_grant_i) stateNext = S_BEGIN;
        end
        S_BEGIN: begin
          bus_request_o          = 1'b1;
          bus_beginTransaction_o = 1'b1;
          bus_addrData_o         = addrQ;
          bus_byteEnables_o      = beQ;
          bus_burstSize_o        = {4'b0, burstQ};
          bus_readNWrite_o       = readQ;
          if (bus_error_i) begin
            error_o   = 1'b1;
            fifoDrop  = !readQ;
            stateNext = S_IDLE;
          end else begin
            stateNext = readQ ? S_RDATA : S_WDATA;
          end
        end
        S_WDATA: begin
          bus_request_o   = 1'b1;
          bus_dataValid_o = 1'b1;
          bus_addrData_o  = fifoHead;
          if (bus_error_i) begin
            // The word on the bus this cycle is not taken; drop it and the rest.
            error_o   = 1'b1;
            fifoDrop  = 1'b1;
            stateNext = S_IDLE;
          end else if (!bus_busy_i) begin
            fifoPop       = 1'b1;
            wordsLeftNext = wordsLeftQ - 5'd1;
            if (wordsLeftQ == 5'd1) stateNext = S_WEND;
          end
        end
        S_WEND: begin
          bus_request_o        = 1'b1;
          bus_endTransaction_o = 1'b1;
          done_o               = 1'b1;
          stateNext            = S_IDLE;
        end
        S_RDATA: begin
          bus_request_o = 1'b1;
          if (bus_dataValid_i && rdCountQ != 5'd31) rdCountNext = rdCountQ + 5'd1;
          if (bus_error_i) begin
            error_o   = 1'b1;
            stateNext = S_IDLE;
          end else if (bus_endTransaction_i) begin
            // Count includes a word arriving together with the end marker.
            if (rdCountNext == burstWords(burstQ)) done_o = 1'b1;
            else                                   error_o = 1'b1;
            stateNext = S_IDLE;
          end
        end
        default: stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      addrQ      <= '0;
      burstQ     <= '0;
      beQ        <= '0;
      readQ      <= 1'b0;
      wordsLeftQ <= '0;
      rdCountQ   <= '0;
      rdValidQ   <= 1'b0;
      rdDataQ    <= '0;
    end else begin
      state <= stateNext;
      if (cmdAccept) begin
        addrQ      <= cmd_addr_i;
        burstQ     <= cmd_burst_i;
        beQ        <= cmd_be_i;
        readQ      <= cmd_read_i;
        wordsLeftQ <= burstWords(cmd_burst_i);
        rdCountQ   <= '0;
      end else begin
        wordsLeftQ <= wordsLeftNext;
        rdCountQ   <= rdCountNext;
      end
      rdValidQ <= (state == S_RDATA) && bus_dataValid_i;
      rdDataQ  <= ((state == S_RDATA) && bus_dataValid_i) ? bus_addrData_i : '0;
    end
  end

  assign rd_valid_o = rdValidQ && !rst_i;
  assign rd_data_o  = rst_i ? '0 : rdDataQ;
  assign wr_full_o  = fifoFull && !rst_i;
  // The count port is 5 bits; deeper buffers report saturated at 31.
  assign wr_count_o = rst_i ? 5'd0 :
                      (fifoCount > CNT_W'(31)) ? 5'd31 : fifoCount[4:0];
  assign dbgState_o = rst_i ? S_IDLE : state;

endmodule

// File: tb/tb_bus_burst_master.sv
module tb_bus_burst_master;
  import bus_burst_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_read;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_burst, cmd_be;
  logic        wr_push, wr_full;
  logic [31:0] wr_data;
  logic [4:0]  wr_count;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, error;
  logic        bus_request, grant;
  logic        b_begin, b_end, b_rnw, b_dv;
  logic [31:0] b_ad;
  logic [3:0]  b_be;
  logic [7:0]  b_burst;
  logic [31:0] sdata;
  logic        sdv, send, busy, berr;
  busState_e   dbg_state;

  bus_burst_master #(.FIFO_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_read_i(cmd_read),
    .cmd_addr_i(cmd_addr), .cmd_burst_i(cmd_burst), .cmd_be_i(cmd_be),
    .wr_push_i(wr_push), .wr_data_i(wr_data), .wr_full_o(wr_full), .wr_count_o(wr_count),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .done_o(done), .error_o(error),
    .bus_request_o(bus_request), .bus_grant_i(grant),
    .bus_beginTransaction_o(b_begin), .bus_endTransaction_o(b_end),
    .bus_addrData_o(b_ad), .bus_byteEnables_o(b_be), .bus_burstSize_o(b_burst),
    .bus_readNWrite_o(b_rnw), .bus_dataValid_o(b_dv),
    .bus_addrData_i(sdata), .bus_dataValid_i(sdv), .bus_endTransaction_i(send),
    .bus_busy_i(busy), .bus_error_i(berr), .dbgState_o(dbg_state)
  );

  logic bus_out_any;
  assign bus_out_any = b_begin | b_end | b_rnw | b_dv | (|b_ad) | (|b_be) | (|b_burst);

  // ---------------- scoreboard / monitor ----------------
  int checks = 0;
  int failures = 0;
  int begin_cnt, end_cnt, dv_cnt, done_cnt, err_cnt, both_cnt, beat_idx;
  logic [31:0] begin_addr;
  logic [7:0]  begin_burst;
  logic        begin_rnw;
  logic [31:0] exp_q[$];
  logic [31:0] wr_cap[$];
  logic [31:0] rd_cap[$];
  logic [31:0] dv_data[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd3 + 32'h1234_5678;
  endfunction

  always @(negedge clk) begin
    if (b_begin) begin
      begin_cnt++;
      begin_addr  = b_ad;
      begin_burst = b_burst;
      begin_rnw   = b_rnw;
    end
    if (b_end) end_cnt++;
    if (b_dv) begin
      dv_cnt++;
      dv_data.push_back(b_ad);
      if (!busy && !berr) begin
        wr_cap.push_back(b_ad);
        beat_idx++;
      end
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
    if (rd_valid) rd_cap.push_back(rd_data);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_cap(input string name, input bit use_rd);
    logic [31:0] got[$];
    if (use_rd) got = rd_cap;
    else        got = wr_cap;
    check({name, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_w%0d", name, i), got[i], exp_q[i]);
  endtask

  task automatic clear_mon();
    begin_cnt = 0; end_cnt = 0; dv_cnt = 0; done_cnt = 0; err_cnt = 0;
    both_cnt = 0; beat_idx = 0; begin_addr = '0; begin_burst = '0; begin_rnw = 1'b0;
    wr_cap.delete(); rd_cap.delete(); dv_data.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    cmd_valid = 0; cmd_read = 0; cmd_addr = '0; cmd_burst = '0; cmd_be = '0;
    wr_push = 0; wr_data = '0; grant = 0; sdata = '0; sdv = 0; send = 0; busy = 0; berr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_push = 1'b1;
      wr_data = base + 32'(i);
      @(posedge clk); #1;
    end
    wr_push = 1'b0;
  endtask

  // Issues one command and plays arbiter + slave until done/error.
  // busy_beat/err_beat: index of the write word to stall/fault (-1 = none).
  // rst_at >= 0: pulse reset once that many read words were delivered.
  task automatic do_cmd(input logic rd, input logic [31:0] addr, input logic [3:0] burst,
                        input int grant_delay, input int busy_beat, input int busy_len,
                        input int err_beat, input int slave_words, input int rst_at,
                        input string tag);
    int  cyc, busy_cnt, slave_idx;
    bit  err_done, accepted;
    clear_mon();
    cmd_valid = 1; cmd_read = rd; cmd_addr = addr; cmd_burst = burst; cmd_be = 4'hF;
    accepted = 0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) accepted = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    check({tag, "_accepted"}, 64'(accepted), 64'd1);
    cyc = 0; busy_cnt = 0; slave_idx = 0; err_done = 0;
    while (accepted && (done_cnt + err_cnt) == 0 && cyc < 100) begin
      grant = (cyc >= grant_delay);
      busy = 0; berr = 0; sdv = 0; send = 0; sdata = '0;
      if (!rd && b_dv) begin
        if (beat_idx == busy_beat && busy_cnt < busy_len) begin busy = 1; busy_cnt++; end
        if (beat_idx == err_beat && !err_done) begin berr = 1; err_done = 1; end
      end
      if (rd && begin_cnt > 0) begin
        if (rst_at >= 0 && slave_idx == rst_at) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          break;
        end
        if (slave_idx < slave_words) begin
          sdv = 1; sdata = mem_word(addr + 32'(4 * slave_idx));
          send = (slave_idx == slave_words - 1);
          slave_idx++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    grant = 0; busy = 0; berr = 0; sdv = 0; send = 0; sdata = '0;
    if (rst_at < 0) begin
      check({tag, "_finished"}, 64'((done_cnt + err_cnt) != 0), 64'd1);
      repeat (2) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- table: buffer level vs command readiness ----------------
  typedef struct {
    int         n_push;
    logic       rd;
    logic [3:0] burst;
    logic       exp_ready;
    logic [4:0] exp_count;
    logic       exp_full;
  } vec_t;
  vec_t vecs[8];

  int held;

  initial begin
    vecs[0] = '{0,  1'b0, 4'd0,  1'b0, 5'd0,  1'b0};
    vecs[1] = '{0,  1'b1, 4'd7,  1'b1, 5'd0,  1'b0};
    vecs[2] = '{1,  1'b0, 4'd0,  1'b1, 5'd1,  1'b0};
    vecs[3] = '{3,  1'b0, 4'd3,  1'b0, 5'd3,  1'b0};
    vecs[4] = '{4,  1'b0, 4'd3,  1'b1, 5'd4,  1'b0};
    vecs[5] = '{15, 1'b0, 4'd15, 1'b0, 5'd15, 1'b0};
    vecs[6] = '{16, 1'b0, 4'd15, 1'b1, 5'd16, 1'b1};
    vecs[7] = '{18, 1'b0, 4'd15, 1'b1, 5'd16, 1'b1};

    // Reset values, with a read command and a push pending.
    rst = 1'b1;
    clear_inputs();
    cmd_valid = 1; cmd_read = 1; wr_push = 1; wr_data = 32'h55;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    check("rst_wr_full", 64'(wr_full), 64'd0);
    check("rst_request", 64'(bus_request), 64'd0);
    check("rst_bus_outs", 64'(bus_out_any), 64'd0);
    check("rst_pulses", 64'({rd_valid, done, error}), 64'd0);
    @(posedge clk); #1;
    clear_inputs();

    foreach (vecs[v]) begin
      do_reset();
      push_words(32'h1000, vecs[v].n_push);
      cmd_read = vecs[v].rd; cmd_burst = vecs[v].burst;
      @(negedge clk);
      check($sformatf("vec%0d_ready", v), 64'(cmd_ready), 64'(vecs[v].exp_ready));
      check($sformatf("vec%0d_count", v), 64'(wr_count), 64'(vecs[v].exp_count));
      check($sformatf("vec%0d_full", v), 64'(wr_full), 64'(vecs[v].exp_full));
      @(posedge clk); #1;
    end

    // Basic 4-word write, grant two cycles after request.
    do_reset();
    push_words(32'hA0, 4);
    exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_cmd(1'b0, 32'h100, 4'd3, 2, -1, 0, -1, 0, -1, "wr4");
    check("wr4_begin_cnt", 64'(begin_cnt), 64'd1);
    check("wr4_begin_addr", 64'(begin_addr), 64'h100);
    check("wr4_begin_burst", 64'(begin_burst), 64'd3);
    check("wr4_begin_rnw", 64'(begin_rnw), 64'd0);
    check("wr4_dv_cnt", 64'(dv_cnt), 64'd4);
    compare_cap("wr4_data", 1'b0);
    check("wr4_end_cnt", 64'(end_cnt), 64'd1);
    check("wr4_done_cnt", 64'(done_cnt), 64'd1);
    check("wr4_err_cnt", 64'(err_cnt), 64'd0);
    check("wr4_wr_count", 64'(wr_count), 64'd0);
    check("wr4_bus_idle", 64'(bus_out_any), 64'd0);

    // Same write with the second word stalled for three cycles.
    do_reset();
    push_words(32'hA0, 4);
    do_cmd(1'b0, 32'h100, 4'd3, 2, 1, 3, -1, 0, -1, "wrbusy");
    check("wrbusy_dv_cnt", 64'(dv_cnt), 64'd7);
    held = 0;
    foreach (dv_data[i]) if (dv_data[i] == 32'hA1) held++;
    check("wrbusy_a1_held", 64'(held), 64'd4);
    compare_cap("wrbusy_data", 1'b0);
    check("wrbusy_done_cnt", 64'(done_cnt), 64'd1);

    // 8-word read from the memory slave.
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(mem_word(32'h0400_0000 + 32'(4 * i)));
    do_cmd(1'b1, 32'h0400_0000, 4'd7, 0, -1, 0, -1, 8, -1, "rd8");
    check("rd8_begin_rnw", 64'(begin_rnw), 64'd1);
    check("rd8_begin_burst", 64'(begin_burst), 64'd7);
    compare_cap("rd8_data", 1'b1);
    check("rd8_done_cnt", 64'(done_cnt), 64'd1);
    check("rd8_err_cnt", 64'(err_cnt), 64'd0);

    // Short read: burst of 4 but slave ends after 2 words.
    exp_q.delete();
    for (int i = 0; i < 2; i++) exp_q.push_back(mem_word(32'h300 + 32'(4 * i)));
    do_cmd(1'b1, 32'h300, 4'd3, 1, -1, 0, -1, 2, -1, "rdshort");
    compare_cap("rdshort_data", 1'b1);
    check("rdshort_err_cnt", 64'(err_cnt), 64'd1);
    check("rdshort_done_cnt", 64'(done_cnt), 64'd0);
    check("rdshort_both", 64'(both_cnt), 64'd0);

    // Bus error on the second word of a 4-word write with 6 words buffered.
    do_reset();
    push_words(32'hB0, 6);
    exp_q = '{32'hB0};
    do_cmd(1'b0, 32'h200, 4'd3, 1, -1, 0, 1, 0, -1, "wrerr");
    check("wrerr_err_cnt", 64'(err_cnt), 64'd1);
    check("wrerr_done_cnt", 64'(done_cnt), 64'd0);
    check("wrerr_end_cnt", 64'(end_cnt), 64'd0);
    check("wrerr_wr_count", 64'(wr_count), 64'd2);
    check("wrerr_bus_idle", 64'(bus_out_any), 64'd0);
    compare_cap("wrerr_data", 1'b0);
    // The surviving words are the two that followed the aborted burst.
    exp_q = '{32'hB4, 32'hB5};
    do_cmd(1'b0, 32'h240, 4'd1, 0, -1, 0, -1, 0, -1, "wrafter");
    compare_cap("wrafter_data", 1'b0);
    check("wrafter_done_cnt", 64'(done_cnt), 64'd1);
    check("wrafter_wr_count", 64'(wr_count), 64'd0);

    // Reset in the middle of a read burst, buffer holding 3 words.
    do_reset();
    push_words(32'hC0, 3);
    do_cmd(1'b1, 32'h0400_0000, 4'd7, 0, -1, 0, -1, 8, 3, "rdrst");
    @(negedge clk);
    check("rdrst_request", 64'(bus_request), 64'd0);
    check("rdrst_bus_outs", 64'(bus_out_any), 64'd0);
    check("rdrst_wr_count", 64'(wr_count), 64'd0);
    @(posedge clk); #1;
    exp_q.delete();
    for (int i = 0; i < 2; i++) exp_q.push_back(mem_word(32'h500 + 32'(4 * i)));
    do_cmd(1'b1, 32'h500, 4'd1, 1, -1, 0, -1, 2, -1, "rdpost");
    compare_cap("rdpost_data", 1'b1);
    check("rdpost_done_cnt", 64'(done_cnt), 64'd1);

    // Command pending across reset release: no request in the first cycle.
    rst = 1'b1;
    clear_inputs();
    cmd_valid = 1; cmd_read = 1; cmd_addr = 32'h600;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("release_no_request", 64'(bus_request), 64'd0);
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    check("release_request_next", 64'(bus_request), 64'd1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
